// File: rtl/video_system_cpu_div_pkg.sv
// Shared constants and state encoding for the execute-stage restoring divider.
package video_system_cpu_div_pkg;

  localparam int DIV_DATA_W = 32;
  localparam int DIV_ITER   = DIV_DATA_W;

  localparam logic [DIV_DATA_W-1:0] DIV0_QUOT = {DIV_DATA_W{1'b1}};

  typedef logic [2:0] div_state_t;

  // state | meaning
  // IDLE  | waiting for start, results held
  // PREP  | record result signs, convert operands to magnitudes
  // CALC  | one restoring step per clock
  // FIXUP | apply signs / divide-by-zero result
  // DONE  | one-cycle done pulse
  localparam div_state_t ST_IDLE  = 3'd0;
  localparam div_state_t ST_PREP  = 3'd1;
  localparam div_state_t ST_CALC  = 3'd2;
  localparam div_state_t ST_FIXUP = 3'd3;
  localparam div_state_t ST_DONE  = 3'd4;

endpackage

// File: rtl/video_system_cpu_div_if.sv
// Request/response bundle between the execute stage and the divider cell.
interface video_system_cpu_div_if #(
  parameter int DATA_W = video_system_cpu_div_pkg::DIV_DATA_W
);

  logic              A_div_start;
  logic              A_div_signed;
  logic              A_div_abort;
  logic [DATA_W-1:0] A_div_src1;
  logic [DATA_W-1:0] A_div_src2;
  logic              A_div_busy;
  logic              A_div_done;
  logic [DATA_W-1:0] A_div_quot;
  logic [DATA_W-1:0] A_div_rem;

  modport master (
    output A_div_start, A_div_signed, A_div_abort, A_div_src1, A_div_src2,
    input  A_div_busy, A_div_done, A_div_quot, A_div_rem
  );

  modport slave (
    input  A_div_start, A_div_signed, A_div_abort, A_div_src1, A_div_src2,
    output A_div_busy, A_div_done, A_div_quot, A_div_rem
  );

endinterface

// File: rtl/video_system_cpu_div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
module video_system_cpu_div_step
  import video_system_cpu_div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic [DATA_W-1:0] rem_in,
  input  logic              dividend_msb,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_out,
  output logic              q_bit
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] trial;

  assign shifted = {rem_in, dividend_msb};
  assign trial   = shifted - {1'b0, divisor};

  // rem_in < divisor keeps shifted below 2*divisor, so the top trial bit is a clean borrow flag
  assign q_bit   = ~trial[DATA_W];
  assign rem_out = q_bit ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];

endmodule

// File: rtl/video_system_cpu_div_cell.sv
// Multi-cycle signed/unsigned restoring divider with start/abort handshake and done pulse.
module video_system_cpu_div_cell
  import video_system_cpu_div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input logic                  clk,
  input logic                  reset_n,
  video_system_cpu_div_if.slave div
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  div_state_t        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] op_a_q;
  logic [DATA_W-1:0] op_b_q;
  logic              signed_q;
  logic              sign_quot_q;
  logic              sign_rem_q;
  logic              div0_q;
  logic [DATA_W-1:0] dvd_q;
  logic [DATA_W-1:0] rem_acc_q;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] quot_q;
  logic [DATA_W-1:0] rem_q;

  logic              neg_a;
  logic              neg_b;
  logic [DATA_W-1:0] mag_a;
  logic [DATA_W-1:0] mag_b;
  logic [DATA_W-1:0] step_rem;
  logic              step_q_bit;

  assign neg_a = signed_q & op_a_q[DATA_W-1];
  assign neg_b = signed_q & op_b_q[DATA_W-1];
  // -2^(W-1) maps onto its own pattern, which is the correct unsigned magnitude
  assign mag_a = neg_a ? -op_a_q : op_a_q;
  assign mag_b = neg_b ? -op_b_q : op_b_q;

  video_system_cpu_div_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .rem_in       (rem_acc_q),
    .dividend_msb (dvd_q[DATA_W-1]),
    .divisor      (op_b_q),
    .rem_out      (step_rem),
    .q_bit        (step_q_bit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      signed_q    <= 1'b0;
      sign_quot_q <= 1'b0;
      sign_rem_q  <= 1'b0;
      div0_q      <= 1'b0;
      dvd_q       <= '0;
      rem_acc_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quot_q      <= '0;
      rem_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (div.A_div_start && !div.A_div_abort) begin
            op_a_q   <= div.A_div_src1;
            op_b_q   <= div.A_div_src2;
            signed_q <= div.A_div_signed;
            busy_q   <= 1'b1;
            state_q  <= ST_PREP;
          end
        end

        ST_PREP: begin
          if (div.A_div_abort) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            sign_quot_q <= neg_a ^ neg_b;
            sign_rem_q  <= neg_a;
            dvd_q       <= mag_a;
            op_b_q      <= mag_b;
            rem_acc_q   <= '0;
            cnt_q       <= CNT_LAST;
            if (op_b_q == '0) begin
              div0_q  <= 1'b1;
              state_q <= ST_FIXUP;
            end else begin
              div0_q  <= 1'b0;
              state_q <= ST_CALC;
            end
          end
        end

        ST_CALC: begin
          if (div.A_div_abort) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            rem_acc_q <= step_rem;
            dvd_q     <= {dvd_q[DATA_W-2:0], step_q_bit};
            cnt_q     <= cnt_q - CNT_W'(1);
            if (cnt_q == '0) begin
              state_q <= ST_FIXUP;
            end
          end
        end

        ST_FIXUP: begin
          if (div.A_div_abort) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            if (div0_q) begin
              quot_q <= {DATA_W{1'b1}};
              rem_q  <= op_a_q;
            end else begin
              quot_q <= sign_quot_q ? -dvd_q : dvd_q;
              rem_q  <= sign_rem_q ? -rem_acc_q : rem_acc_q;
            end
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign div.A_div_busy = busy_q;
  assign div.A_div_done = done_q;
  assign div.A_div_quot = quot_q;
  assign div.A_div_rem  = rem_q;

endmodule

// File: tb/tb_video_system_cpu_div_cell.sv
// Self-checking bench for the restoring divider: directed corner cases plus randomized ops.
module tb_video_system_cpu_div_cell;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;

  video_system_cpu_div_if #(.DATA_W(W)) dif ();

  video_system_cpu_div_cell #(.DATA_W(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .div     (dif)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic; C-style truncating division in 64 bits.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
    longint sa, sb;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (sgn) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      q = W'(sa / sb);
      r = W'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Issues one op, waits for done, then steps into the cycle after done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output int lat, output int busy_cnt, output logic done_after);
    logic ok;
    ok = 1'b0;
    q = '0;
    r = '0;
    lat = 0;
    busy_cnt = 0;
    dif.A_div_src1 = a;
    dif.A_div_src2 = b;
    dif.A_div_signed = sgn;
    dif.A_div_start = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      dif.A_div_start = 1'b0;
      lat++;
      if (dif.A_div_busy) busy_cnt++;
      if (dif.A_div_done) begin
        ok = 1'b1;
        q = dif.A_div_quot;
        r = dif.A_div_rem;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL done_timeout got=no_done exp=done a=%h b=%h", a, b);
    end else begin
      last_q = q;
      last_r = r;
    end
    tick();
    done_after = dif.A_div_done;
  endtask

  task automatic test_reset;
    dif.A_div_start = 1'b0;
    dif.A_div_signed = 1'b0;
    dif.A_div_abort = 1'b0;
    dif.A_div_src1 = '0;
    dif.A_div_src2 = '0;
    reset_n = 1'b0;
    tick();
    tick();
    total++;
    if ({dif.A_div_busy, dif.A_div_done} !== 2'b00) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=00", {dif.A_div_busy, dif.A_div_done});
    end
    total++;
    if (dif.A_div_quot !== '0 || dif.A_div_rem !== '0) begin
      bad++;
      $display("FAIL reset_data got=%h/%h exp=0/0", dif.A_div_quot, dif.A_div_rem);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_unsigned_basic;
    logic [W-1:0] q, r;
    int lat, bc;
    logic da;
    run_op(32'd100, 32'd7, 1'b0, q, r, lat, bc, da);
    total++;
    if (q !== 32'd14 || r !== 32'd2) begin
      bad++;
      $display("FAIL basic_100_7 got=%0d/%0d exp=14/2", q, r);
    end
    total++;
    if (lat !== 35) begin
      bad++;
      $display("FAIL basic_latency got=%0d exp=35", lat);
    end
    total++;
    if (bc !== 34) begin
      bad++;
      $display("FAIL basic_busy_cycles got=%0d exp=34", bc);
    end
    total++;
    if (da !== 1'b0) begin
      bad++;
      $display("FAIL done_width got=%b exp=0", da);
    end
  endtask

  task automatic test_sign_modes;
    logic [W-1:0] q, r;
    int lat, bc;
    logic da;
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, q, r, lat, bc, da);
    total++;
    if (q !== 32'hFFFF_FFFD || r !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL signed_m7_2 got=%h/%h exp=fffffffd/ffffffff", q, r);
    end
    run_op(32'hFFFF_FFF9, 32'd2, 1'b0, q, r, lat, bc, da);
    total++;
    if (q !== 32'h7FFF_FFFC || r !== 32'd1) begin
      bad++;
      $display("FAIL unsigned_fff9_2 got=%h/%h exp=7ffffffc/00000001", q, r);
    end
  endtask

  task automatic test_div_zero;
    logic [W-1:0] q, r;
    int lat, bc;
    for (int s = 0; s < 2; s++) begin
      logic da;
      run_op(32'h1234_5678, 32'd0, s[0], q, r, lat, bc, da);
      total++;
      if (q !== 32'hFFFF_FFFF || r !== 32'h1234_5678) begin
        bad++;
        $display("FAIL div0_result sgn=%0d got=%h/%h exp=ffffffff/12345678", s, q, r);
      end
      total++;
      if (lat !== 3) begin
        bad++;
        $display("FAIL div0_latency sgn=%0d got=%0d exp=3", s, lat);
      end
    end
  endtask

  task automatic test_overflow;
    logic [W-1:0] q, r;
    int lat, bc;
    logic da;
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, q, r, lat, bc, da);
    total++;
    if (q !== 32'h8000_0000 || r !== 32'd0) begin
      bad++;
      $display("FAIL signed_overflow got=%h/%h exp=80000000/00000000", q, r);
    end
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, q, r, lat, bc, da);
    total++;
    if (q !== 32'd0 || r !== 32'h8000_0000) begin
      bad++;
      $display("FAIL unsigned_8000_ffff got=%h/%h exp=00000000/80000000", q, r);
    end
  endtask

  task automatic test_abort;
    logic [W-1:0] q0, r0;
    int dones, lat;
    logic got;
    q0 = last_q;
    r0 = last_r;
    dif.A_div_src1 = 32'd1000;
    dif.A_div_src2 = 32'd10;
    dif.A_div_signed = 1'b0;
    dif.A_div_start = 1'b1;
    tick();
    dif.A_div_start = 1'b0;
    for (int i = 2; i <= 10; i++) tick();
    dif.A_div_abort = 1'b1;
    tick();
    dif.A_div_abort = 1'b0;
    total++;
    if (dif.A_div_busy !== 1'b0 || dif.A_div_done !== 1'b0) begin
      bad++;
      $display("FAIL abort_busy_drop got=%b%b exp=00", dif.A_div_busy, dif.A_div_done);
    end
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (dif.A_div_done === 1'b1) dones++;
    end
    total++;
    if (dones !== 0) begin
      bad++;
      $display("FAIL abort_no_done got=%0d exp=0", dones);
    end
    total++;
    if (dif.A_div_quot !== q0 || dif.A_div_rem !== r0) begin
      bad++;
      $display("FAIL abort_hold got=%h/%h exp=%h/%h", dif.A_div_quot, dif.A_div_rem, q0, r0);
    end
    // start and abort together in IDLE: nothing must be accepted
    dif.A_div_src1 = 32'd5;
    dif.A_div_src2 = 32'd5;
    dif.A_div_start = 1'b1;
    dif.A_div_abort = 1'b1;
    tick();
    dif.A_div_start = 1'b0;
    dif.A_div_abort = 1'b0;
    tick();
    total++;
    if (dif.A_div_busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_beats_start got=%b exp=0", dif.A_div_busy);
    end
    // restart, and pulse start with other operands while busy
    dif.A_div_src1 = 32'd1000;
    dif.A_div_src2 = 32'd10;
    dif.A_div_start = 1'b1;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      tick();
      lat++;
      if (lat >= 3 && lat <= 6) begin
        dif.A_div_src1 = 32'd5;
        dif.A_div_src2 = 32'd5;
        dif.A_div_start = 1'b1;
      end else begin
        dif.A_div_start = 1'b0;
      end
      if (dif.A_div_done === 1'b1) got = 1'b1;
    end
    total++;
    if (!got || dif.A_div_quot !== 32'd100 || dif.A_div_rem !== 32'd0 || lat !== 35) begin
      bad++;
      $display("FAIL start_while_busy got=%h/%h lat=%0d exp=00000064/00000000 lat=35",
               dif.A_div_quot, dif.A_div_rem, lat);
    end
    dif.A_div_start = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (dif.A_div_done === 1'b1 || dif.A_div_busy === 1'b1) dones++;
    end
    total++;
    if (dones !== 0) begin
      bad++;
      $display("FAIL ignored_start_ran got=%0d exp=0", dones);
    end
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] q, r;
    int lat, bc;
    logic da;
    dif.A_div_src1 = 32'h7FFF_FFFF;
    dif.A_div_src2 = 32'd3;
    dif.A_div_signed = 1'b0;
    dif.A_div_start = 1'b1;
    tick();
    dif.A_div_start = 1'b0;
    for (int i = 0; i < 21; i++) tick();
    reset_n = 1'b0;
    #1;
    total++;
    if (dif.A_div_busy !== 1'b0 || dif.A_div_done !== 1'b0 ||
        dif.A_div_quot !== '0 || dif.A_div_rem !== '0) begin
      bad++;
      $display("FAIL async_reset got=%b%b %h/%h exp=00 0/0", dif.A_div_busy, dif.A_div_done,
               dif.A_div_quot, dif.A_div_rem);
    end
    tick();
    tick();
    #2;
    reset_n = 1'b1;
    bc = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (dif.A_div_done === 1'b1) bc++;
    end
    total++;
    if (bc !== 0) begin
      bad++;
      $display("FAIL reset_no_done got=%0d exp=0", bc);
    end
    run_op(32'd9, 32'd3, 1'b0, q, r, lat, bc, da);
    total++;
    if (q !== 32'd3 || r !== 32'd0) begin
      bad++;
      $display("FAIL after_reset_9_3 got=%0d/%0d exp=3/0", q, r);
    end
  endtask

  function automatic logic [W-1:0] pick_operand(input bit is_divisor);
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0: v = is_divisor ? 32'd0 : 32'h8000_0000;
      1: v = is_divisor ? 32'hFFFF_FFFF : 32'($urandom_range(0, 1000));
      2: v = 32'($urandom_range(1, 20));
      3: v = -32'($urandom_range(1, 20));
      4: v = 32'h7FFF_FFFF;
      default: v = $urandom();
    endcase
    return v;
  endfunction

  task automatic test_random(input int n, input string tag);
    logic [W-1:0] a, b, q, r, eq, er;
    logic sgn, da;
    int lat, bc, elat;
    for (int k = 0; k < n; k++) begin
      a = pick_operand(1'b0);
      b = pick_operand(1'b1);
      sgn = 1'($urandom_range(0, 1));
      ref_div(a, b, sgn, eq, er);
      elat = (b == '0) ? 3 : 35;
      run_op(a, b, sgn, q, r, lat, bc, da);
      total++;
      if (q !== eq || r !== er) begin
        bad++;
        $display("FAIL %s_result a=%h b=%h s=%b got=%h/%h exp=%h/%h", tag, a, b, sgn, q, r, eq, er);
      end
      total++;
      if (lat !== elat || da !== 1'b0) begin
        bad++;
        $display("FAIL %s_timing a=%h b=%h got=%0d/%b exp=%0d/0", tag, a, b, lat, da, elat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_basic();
    test_sign_modes();
    test_div_zero();
    test_overflow();
    test_abort();
    test_reset_mid();
    test_random(8, "back_to_back");
    test_random(1200, "random");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
